// File: rtl/io_controller.sv
// io_controller: memory-mapped IO block with TX FIFO, RX holding register, LEDs and retired-instruction counter
module io_controller (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  clk_sequence,
  input  logic        alive,
  input  logic        exported_wren,
  input  logic [31:0] exported_address,
  input  logic [31:0] exported_data,
  output logic [31:0] io_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  leds
);
  logic [7:0]  mem_q [8];
  logic [2:0]  rd_q, rd_d, wr_q, wr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d, rx_full_q, rx_full_d;
  logic [7:0]  rx_hold_q, rx_hold_d, leds_q, leds_d;
  logic [31:0] instret_q, instret_d;
  logic        io_sel, wr, pop, push, push_ok, cap, tx_full, tx_empty;
  logic [2:0]  idx;
  logic [4:0]  status;

  assign io_sel   = exported_address[31:30] == 2'b01;
  assign idx      = exported_address[4:2];
  assign wr       = exported_wren & clk_sequence[4] & io_sel;
  assign tx_empty = cnt_q == 4'd0;
  assign tx_full  = cnt_q == 4'd8;
  assign tx_valid = ~tx_empty;
  assign tx_data  = mem_q[rd_q];
  assign pop      = tx_valid & tx_ready;
  assign push     = wr & (idx == 3'd0);
  // A full FIFO still takes a push when a pop frees a slot in the same cycle
  assign push_ok  = push & (~tx_full | pop);
  assign rx_ready = ~rx_full_q;
  assign cap      = rx_valid & rx_ready;
  assign leds     = leds_q;
  assign status   = {ovf_q, rx_full_q, tx_full, tx_empty, tx_valid};

  // Next-state for all control registers; set of tx_ovf beats a same-cycle STATUS clear, INSTRET write beats increment
  always_comb begin
    rd_d      = pop ? rd_q + 3'd1 : rd_q;
    wr_d      = push_ok ? wr_q + 3'd1 : wr_q;
    cnt_d     = cnt_q + {3'b0, push_ok} - {3'b0, pop};
    ovf_d     = (push & ~push_ok) | (ovf_q & ~(wr & (idx == 3'd1)));
    rx_full_d = cap | (rx_full_q & ~(wr & (idx == 3'd2)));
    rx_hold_d = cap ? rx_data : rx_hold_q;
    leds_d    = (wr & (idx == 3'd3)) ? exported_data[7:0] : leds_q;
    instret_d = (wr & (idx == 3'd4)) ? 32'd0 :
                (clk_sequence[6] & alive) ? instret_q + 32'd1 : instret_q;
  end

  // Combinational read path for the IO address space
  always_comb begin
    io_data = !io_sel      ? 32'd0 :
              idx == 3'd1  ? {27'b0, status} :
              idx == 3'd2  ? {24'b0, rx_hold_q} :
              idx == 3'd3  ? {24'b0, leds_q} :
              idx == 3'd4  ? instret_q : 32'd0;
  end

  // FIFO storage is never reset; it is only visible while non-empty
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= exported_data[7:0];
  end

  // Control state with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q      <= '0;
      wr_q      <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      rx_full_q <= 1'b0;
      rx_hold_q <= '0;
      leds_q    <= '0;
      instret_q <= '0;
    end else begin
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      rx_full_q <= rx_full_d;
      rx_hold_q <= rx_hold_d;
      leds_q    <= leds_d;
      instret_q <= instret_d;
    end
  end
endmodule

// File: tb/tb_io_controller.sv
// tb_io_controller: directed test of io_controller against a queue-based behavioural model
module tb_io_controller;
  logic        clk, rst_n, alive, exported_wren, tx_valid, tx_ready, rx_valid, rx_ready;
  logic [6:0]  clk_sequence;
  logic [31:0] exported_address, exported_data, io_data;
  logic [7:0]  tx_data, rx_data, leds;
  int          checks = 0, errors = 0;

  logic [7:0]  q[$];
  logic        m_ovf, m_rxf;
  logic [7:0]  m_rxh, m_led;
  logic [31:0] m_ins;

  localparam logic [6:0] PH4 = 7'b0010000;
  localparam logic [6:0] PH6 = 7'b1000000;

  io_controller dut (
    .clk(clk), .rst_n(rst_n), .clk_sequence(clk_sequence), .alive(alive),
    .exported_wren(exported_wren), .exported_address(exported_address),
    .exported_data(exported_data), .io_data(io_data), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .leds(leds)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a[31:30] != 2'b01) return 32'd0;
    case (a[4:2])
      3'd1: return {27'b0, m_ovf, m_rxf, q.size() == 8, q.size() == 0, q.size() != 0};
      3'd2: return {24'b0, m_rxh};
      3'd3: return {24'b0, m_led};
      3'd4: return m_ins;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_rxf = 0; m_rxh = 0; m_led = 0; m_ins = 0;
  endtask

  task automatic model_update();
    logic pop, w, cap, setovf;
    logic [2:0] idx;
    logic [7:0] dummy;
    if (!rst_n) return;
    pop = tx_ready && q.size() > 0;
    w = exported_wren && clk_sequence[4] && exported_address[31:30] == 2'b01;
    idx = exported_address[4:2];
    cap = rx_valid && !m_rxf;
    setovf = 0;
    if (pop) dummy = q.pop_front();
    if (w && idx == 0) begin
      if (q.size() < 8) q.push_back(exported_data[7:0]);
      else setovf = 1;
    end
    if (w && idx == 1) m_ovf = 0;
    if (setovf) m_ovf = 1;
    if (w && idx == 2) m_rxf = 0;
    if (cap) begin m_rxf = 1; m_rxh = rx_data; end
    if (w && idx == 3) m_led = exported_data[7:0];
    if (clk_sequence[6] && alive) m_ins = m_ins + 1;
    if (w && idx == 4) m_ins = 0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cmp_tx_valid", {31'b0, tx_valid}, {31'b0, q.size() != 0});
      if (q.size() != 0) chk("cmp_tx_data", {24'b0, tx_data}, {24'b0, q[0]});
      chk("cmp_rx_ready", {31'b0, rx_ready}, {31'b0, !m_rxf});
      chk("cmp_leds", {24'b0, leds}, {24'b0, m_led});
      chk("cmp_io_data", io_data, model_read(exported_address));
    end
  end

  task automatic step();
    @(posedge clk);
    #1 model_update();
    @(negedge clk);
    #2;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [6:0] seq);
    exported_address = a; exported_data = d; exported_wren = 1; clk_sequence = seq;
    step();
    exported_wren = 0; clk_sequence = 0;
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    exported_address = a; exported_wren = 0;
    #1 chk(name, io_data, exp);
  endtask

  initial begin
    logic [7:0] drain [8];
    drain = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h99};
    rst_n = 0; alive = 0; exported_wren = 0; clk_sequence = 0;
    exported_address = 0; exported_data = 0; tx_ready = 0; rx_valid = 0; rx_data = 0;
    model_reset();
    #1;
    chk("rst_tx_valid", {31'b0, tx_valid}, 0);
    chk("rst_rx_ready", {31'b0, rx_ready}, 1);
    chk("rst_leds", {24'b0, leds}, 0);
    rd("rst_status", 32'h40000004, 32'h2);
    #11 rst_n = 1;
    step();
    // TX basic
    store(32'h40000000, 32'h41, PH4);
    store(32'h40000000, 32'h42, PH4);
    chk("tx_valid_1", {31'b0, tx_valid}, 1);
    chk("tx_head_41", {24'b0, tx_data}, 32'h41);
    rd("status_one", 32'h40000004, 32'h1);
    tx_ready = 1;
    step();
    chk("tx_head_42", {24'b0, tx_data}, 32'h42);
    step();
    tx_ready = 0;
    chk("tx_drained", {31'b0, tx_valid}, 0);
    rd("status_empty", 32'h40000004, 32'h2);
    // Overflow
    for (int i = 0; i < 9; i++) store(32'h40000000, 32'h10 + i, PH4);
    rd("status_ovf", 32'h40000004, 32'h15);
    store(32'h40000004, 32'h0, PH4);
    rd("status_ovf_clr", 32'h40000004, 32'h5);
    // Push at full with concurrent pop
    tx_ready = 1;
    store(32'h40000000, 32'h99, PH4);
    tx_ready = 0;
    rd("status_full_pp", 32'h40000004, 32'h5);
    tx_ready = 1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_byte", {24'b0, tx_data}, {24'b0, drain[i]});
      step();
    end
    tx_ready = 0;
    chk("drain_done", {31'b0, tx_valid}, 0);
    // RX path
    rx_valid = 1; rx_data = 8'h5A;
    step();
    rx_data = 8'h33;
    chk("rx_ready_full", {31'b0, rx_ready}, 0);
    rd("rx_read_5a", 32'h40000008, 32'h5A);
    step();
    rd("rx_hold_off", 32'h40000008, 32'h5A);
    store(32'h40000008, 32'h0, PH4);
    chk("rx_ready_pop", {31'b0, rx_ready}, 1);
    step();
    rx_valid = 0;
    rd("rx_read_33", 32'h40000008, 32'h33);
    // LEDs and decode
    store(32'h4000000C, 32'hA5, PH4);
    chk("leds_a5", {24'b0, leds}, 32'hA5);
    rd("leds_read", 32'h4000000C, 32'hA5);
    rd("no_sel", 32'h00000010, 32'h0);
    store(32'h4000000C, 32'h5A, 7'b0);
    store(32'h0000000C, 32'h5A, PH4);
    chk("leds_kept", {24'b0, leds}, 32'hA5);
    rd("idx5_zero", 32'h40000014, 32'h0);
    // INSTRET
    alive = 1; clk_sequence = PH6;
    for (int i = 0; i < 10; i++) step();
    alive = 0;
    step();
    clk_sequence = 0;
    rd("instret_10", 32'h40000010, 32'd10);
    alive = 1;
    store(32'h40000010, 32'h0, PH4 | PH6);
    alive = 0;
    rd("instret_wr_wins", 32'h40000010, 32'd0);
    alive = 1; clk_sequence = PH6;
    for (int i = 0; i < 3; i++) step();
    clk_sequence = 0; alive = 0;
    // Async reset mid-run
    for (int i = 0; i < 3; i++) store(32'h40000000, 32'hC0 + i, PH4);
    chk("pre_rst_valid", {31'b0, tx_valid}, 1);
    rst_n = 0;
    model_reset();
    #1;
    chk("async_tx_valid", {31'b0, tx_valid}, 0);
    chk("async_leds", {24'b0, leds}, 0);
    rd("async_instret", 32'h40000010, 32'h0);
    rd("async_status", 32'h40000004, 32'h2);
    #3 rst_n = 1;
    store(32'h40000000, 32'h77, PH4);
    chk("post_rst_push", {24'b0, tx_data}, 32'h77);
    rd("post_rst_status", 32'h40000004, 32'h1);
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
